// File: rtl/led_counter_ctrl.sv
`default_nettype none
// led_counter_ctrl: command-driven 6-bit up/down counter with a prescaled free-run mode,
// active-low LED outputs and a one-cycle wrap pulse.
module led_counter_ctrl #(
  parameter int PRESCALE = 13500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [5:0] cmd_data,
  output logic [5:0] count,
  output logic [5:0] led,
  output logic       busy,
  output logic       wrap
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;

  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_DIR   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  logic [1:0]    state;
  logic          dir;
  logic [PW-1:0] prescaler;

  logic       accept;
  logic       tick;
  logic [5:0] adv_count;
  logic       adv_wrap;

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    tick      = (state == S_RUN) && (prescaler == PS_LAST);
    adv_count = dir ? (count - 6'd1) : (count + 6'd1);
    adv_wrap  = dir ? (count == 6'd0) : (count == 6'd63);
  end

  assign cmd_ready = (state != S_STEP);
  assign busy      = (state == S_RUN);
  assign led       = ~count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= 6'd0;
      dir       <= 1'b0;
      prescaler <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_START: begin
                state     <= S_RUN;
                prescaler <= '0;
              end
              OP_STEP:  state <= S_STEP;
              OP_LOAD: begin
                count     <= cmd_data;
                prescaler <= '0;
              end
              OP_CLEAR: begin
                count     <= 6'd0;
                prescaler <= '0;
              end
              OP_DIR:   dir <= cmd_data[0];
              default: ;
            endcase
          end
        end

        S_RUN: begin
          // STOP, LOAD and CLEAR override a coincident tick; DIR lets the tick use the old direction.
          if (accept && (cmd_op == OP_STOP)) begin
            state     <= S_IDLE;
            prescaler <= '0;
          end else if (accept && (cmd_op == OP_LOAD)) begin
            count     <= cmd_data;
            prescaler <= '0;
          end else if (accept && (cmd_op == OP_CLEAR)) begin
            count     <= 6'd0;
            prescaler <= '0;
          end else begin
            if (tick) begin
              prescaler <= '0;
              count     <= adv_count;
              wrap      <= adv_wrap;
            end else begin
              prescaler <= prescaler + PW'(1);
            end
            if (accept && (cmd_op == OP_DIR)) dir <= cmd_data[0];
          end
        end

        S_STEP: begin
          count <= adv_count;
          wrap  <= adv_wrap;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/led_counter_ctrl.md
LED_COUNTER_CTRL -- requirements
Module: led_counter_ctrl

Interface
REQ-001 Parameter PRESCALE, default 13500000, clk cycles per count advance in RUN; the block SHALL support any value >= 1.
REQ-002 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  block can accept a command this cycle.
REQ-006 cmd_op  in  3  opcode: 0 NOP, 1 START, 2 STOP, 3 STEP, 4 LOAD, 5 DIR, 6 CLEAR, 7 reserved (NOP).
REQ-007 cmd_data  in  6  LOAD value; bit 0 is the direction for DIR (0 up, 1 down).
REQ-008 count  out  6  current counter value.
REQ-009 led  out  6  active-low board LEDs; SHALL equal ~count at all times.
REQ-010 busy  out  1  high while in state RUN.
REQ-011 wrap  out  1  one-cycle pulse on each counter wrap.

Function
REQ-012 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; no other command input SHALL have effect.
REQ-013 The FSM SHALL have states IDLE, RUN, STEP; cmd_ready SHALL be 0 in STEP and 1 otherwise.
REQ-014 IDLE: START -> RUN; STEP -> STEP; STOP/NOP/reserved -> no state change.
REQ-015 RUN: STOP -> IDLE; START and STEP SHALL be ignored.
REQ-016 STEP: state SHALL be exactly one cycle; on its exiting edge count advances by one in the current direction, then IDLE.
REQ-017 LOAD (count <= cmd_data), CLEAR (count <= 0) and DIR (dir <= cmd_data[0]) SHALL take effect on the accepting edge in IDLE or RUN, without changing state.
REQ-018 Prescaler: 0..PRESCALE-1, counts only in RUN; an edge with prescaler == PRESCALE-1 is a tick, returns prescaler to 0 and advances count.
REQ-019 Prescaler SHALL be cleared on entry to RUN, on STOP, and on LOAD or CLEAR.
REQ-020 First tick after START SHALL occur PRESCALE edges after the accepting edge; with PRESCALE=1 count advances every cycle in RUN.
REQ-021 Advance: up = count+1, down = count-1, modulo 64; 63->0 (up) and 0->63 (down) SHALL assert wrap for the following cycle only.
REQ-022 LOAD or CLEAR coinciding with a tick SHALL win: count takes the loaded value, no advance, no wrap.
REQ-023 STOP coinciding with a tick SHALL suppress that advance.
REQ-024 DIR coinciding with a tick: the tick SHALL use the old direction.
REQ-025 LOAD/CLEAR never assert wrap.

Reset
REQ-026 While rst_n = 0, immediately and regardless of clk: state IDLE, count 0, dir 0 (up), prescaler 0, wrap 0, busy 0, cmd_ready 1, led 6'h3F.
REQ-027 Reset asserted mid-RUN or mid-STEP SHALL abort the operation with no further count change; after release the block SHALL be in IDLE until START.

Verification (PRESCALE=4)
REQ-028 Reset release, START -> busy=1 next cycle; count 1,2,3 at 4,8,12 edges after acceptance; led = ~count.
REQ-029 LOAD 62, START -> count 63, then 0 with wrap high exactly one cycle, then 1.
REQ-030 IDLE, DIR 1, STEP from 0 -> cmd_ready=0 for one cycle, count=63, wrap pulse, state IDLE.
REQ-031 RUN, LOAD 10 on a tick edge -> count=10 (not 11), next advance 4 edges later to 11.
REQ-032 RUN, STOP on a tick edge -> no advance, busy=0; repeat STEP in RUN -> ignored.
REQ-033 rst_n low mid-RUN at count 5 -> count=0, led=6'h3F, busy=0 before next clk edge; stays IDLE after release.
